pipe_stage_elastic: RTL and testbench

Parametrised successor to the fixed-field inter-stage pipeline registers. It is an elastic pipeline stage for any payload width and control bundle. It carries a valid/ready handshake, global stall (freeze), synchronous flush and an optional 2-entry skid buffer. It sits between any two datapath stages (e.g. MEM->WB, EX->MEM) and turns empty slots into bubbles whose control bits are forced to zero.

---
 rtl/pipe_stage_elastic.sv | 157 +++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline stage between two datapath stages. It carries a
//   valid/ready handshake, a global stall (freeze), a synchronous flush and an
//   optional 2-entry skid buffer. Empty slots leave the stage as bubbles whose
//   control bits read as zero.
//
// Parameters
//   DATA_W  payload width
//   CTRL_W  control-bit width (zeroed on bubbles)
//   SKID_EN 1: main + skid entries, registered in_ready_o
//           0: single register, in_ready_o passes out_ready_i through
//
// Ports
//   clk_i        rising-edge clock
//   start_i      asynchronous active-low reset
//   stall_i      freeze: no push, no pop, state held
//   flush_i      synchronous invalidate of all entries (beats stall and push)
//   in_valid_i   upstream entry valid
//   in_ready_o   stage can accept
//   in_data_i    upstream payload
//   in_ctrl_i    upstream control bits
//   out_valid_o  head entry valid
//   out_ready_i  downstream accepts
//   out_data_o   head payload
//   out_ctrl_o   head control, 0 when out_valid_o = 0
//   occ_o        number of entries held (0..2)
module pipe_stage_elastic #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CTRL_W  = 2,
  parameter int unsigned SKID_EN = 1
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occ_o
);

  // State value equals occupancy: main valid in ONE and TWO, skid valid in TWO.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] main_data, main_data_n;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_n;
  logic [DATA_W-1:0] skid_data, skid_data_n;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;

  logic main_valid;
  logic skid_valid;
  logic can_accept;
  logic push;
  logic pop;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);

  // With the skid buffer, readiness depends only on local state, so there is
  // no combinational path from out_ready_i to in_ready_o.
  always_comb begin
    if (SKID_EN != 0) begin
      can_accept = !skid_valid;
    end else begin
      can_accept = !main_valid || out_ready_i;
    end
  end

  assign in_ready_o = can_accept && !stall_i;
  assign push       = in_valid_i && in_ready_o && !stall_i && !flush_i;
  assign pop        = main_valid && out_ready_i && !stall_i && !flush_i;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state     <= state_n;
      main_data <= main_data_n;
      main_ctrl <= main_ctrl_n;
      skid_data <= skid_data_n;
      skid_ctrl <= skid_ctrl_n;
    end
  end

  always_comb begin
    state_n     = state;
    main_data_n = main_data;
    main_ctrl_n = main_ctrl;
    skid_data_n = skid_data;
    skid_ctrl_n = skid_ctrl;

    if (flush_i) begin
      // Data may keep stale values; control is cleared so nothing leaks.
      state_n     = EMPTY;
      main_ctrl_n = '0;
      skid_ctrl_n = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_n     = ONE;
            main_data_n = in_data_i;
            main_ctrl_n = in_ctrl_i;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data_n = in_data_i;
            main_ctrl_n = in_ctrl_i;
          end else if (push) begin
            if (SKID_EN != 0) begin
              state_n     = TWO;
              skid_data_n = in_data_i;
              skid_ctrl_n = in_ctrl_i;
            end else begin
              main_data_n = in_data_i;
              main_ctrl_n = in_ctrl_i;
            end
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_n     = ONE;
            main_data_n = skid_data;
            main_ctrl_n = skid_ctrl;
            skid_ctrl_n = '0;
          end
        end
        default: begin
          state_n = EMPTY;
        end
      endcase
    end
  end

  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign out_ctrl_o  = main_valid ? main_ctrl : '0;
  assign occ_o       = 2'(state);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: one instance with the skid buffer
// and one without, sharing the same upstream/downstream stimulus.
module tb_pipe_stage_elastic;

  logic       clk = 1'b0;
  logic       start;
  logic       stall;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_ctrl;
  logic       out_ready;

  logic       s_in_ready, s_out_valid;
  logic [7:0] s_out_data;
  logic [1:0] s_out_ctrl, s_occ;
  logic       n_in_ready, n_out_valid;
  logic [7:0] n_out_data;
  logic [1:0] n_out_ctrl, n_occ;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(8), .CTRL_W(2), .SKID_EN(1)) u_skid (
    .clk_i(clk), .start_i(start), .stall_i(stall), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_data_i(in_data),
    .in_ctrl_i(in_ctrl), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
    .out_data_o(s_out_data), .out_ctrl_o(s_out_ctrl), .occ_o(s_occ)
  );

  pipe_stage_elastic #(.DATA_W(8), .CTRL_W(2), .SKID_EN(0)) u_noskid (
    .clk_i(clk), .start_i(start), .stall_i(stall), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(n_in_ready), .in_data_i(in_data),
    .in_ctrl_i(in_ctrl), .out_valid_o(n_out_valid), .out_ready_i(out_ready),
    .out_data_o(n_out_data), .out_ctrl_o(n_out_ctrl), .occ_o(n_occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    #12;
    checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid got=%b want=0", s_out_valid); end
    checks++; if (s_occ !== 2'd0) begin failures++; $display("FAIL reset_s_occ got=%0d want=0", s_occ); end
    checks++; if (s_out_ctrl !== 2'b00) begin failures++; $display("FAIL reset_s_ctrl got=%b want=00", s_out_ctrl); end
    checks++; if (s_out_data !== 8'h00) begin failures++; $display("FAIL reset_s_data got=%h want=00", s_out_data); end
    checks++; if (n_out_valid !== 1'b0 || n_occ !== 2'd0) begin failures++; $display("FAIL reset_n got valid=%b occ=%0d want 0/0", n_out_valid, n_occ); end
    start = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_ctrl   = 2'b11;
    for (int unsigned i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      checks++; if (s_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got s=%b n=%b want 1/1", i, s_in_ready, n_in_ready); end
      tick();
      checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'(i) || s_out_ctrl !== 2'b11 || s_occ !== 2'd1) begin failures++; $display("FAIL stream_s[%0d] got v=%b d=%h c=%b occ=%0d want 1/%h/11/1", i, s_out_valid, s_out_data, s_out_ctrl, s_occ, 8'(i)); end
      checks++; if (n_out_valid !== 1'b1 || n_out_data !== 8'(i) || n_out_ctrl !== 2'b11 || n_occ !== 2'd1) begin failures++; $display("FAIL stream_n[%0d] got v=%b d=%h c=%b occ=%0d want 1/%h/11/1", i, n_out_valid, n_out_data, n_out_ctrl, n_occ, 8'(i)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || s_out_ctrl !== 2'b00) begin failures++; $display("FAIL stream_drain got v=%b occ=%0d c=%b want 0/0/00", s_out_valid, s_occ, s_out_ctrl); end
  endtask

  task automatic test_skid_fill();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'h0A; in_ctrl = 2'b01;
    tick();
    checks++; if (s_occ !== 2'd1 || s_out_data !== 8'h0A) begin failures++; $display("FAIL skid_first got occ=%0d d=%h want 1/0a", s_occ, s_out_data); end
    in_data = 8'h0B; in_ctrl = 2'b10;
    #1;
    checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_one got=%b want=1", s_in_ready); end
    checks++; if (n_in_ready !== 1'b0) begin failures++; $display("FAIL noskid_ready_blocked got=%b want=0", n_in_ready); end
    tick();
    checks++; if (s_occ !== 2'd2 || s_out_data !== 8'h0A || s_out_ctrl !== 2'b01) begin failures++; $display("FAIL skid_full got occ=%0d d=%h c=%b want 2/0a/01", s_occ, s_out_data, s_out_ctrl); end
    checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL skid_full_ready got=%b want=0", s_in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (s_occ !== 2'd1 || s_out_data !== 8'h0B || s_out_ctrl !== 2'b10) begin failures++; $display("FAIL skid_pop1 got occ=%0d d=%h c=%b want 1/0b/10", s_occ, s_out_data, s_out_ctrl); end
    tick();
    checks++; if (s_occ !== 2'd0 || s_out_valid !== 1'b0 || s_out_ctrl !== 2'b00) begin failures++; $display("FAIL skid_pop2 got occ=%0d v=%b c=%b want 0/0/00", s_occ, s_out_valid, s_out_ctrl); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'h21; in_ctrl = 2'b01;
    tick();
    in_data = 8'h22; in_ctrl = 2'b10; stall = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (s_in_ready !== 1'b0 || n_in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got s=%b n=%b want 0/0", s_in_ready, n_in_ready); end
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h21 || s_out_ctrl !== 2'b01 || s_occ !== 2'd1) begin failures++; $display("FAIL stall_s[%0d] got v=%b d=%h c=%b occ=%0d want 1/21/01/1", c, s_out_valid, s_out_data, s_out_ctrl, s_occ); end
      checks++; if (n_out_valid !== 1'b1 || n_out_data !== 8'h21 || n_occ !== 2'd1) begin failures++; $display("FAIL stall_n[%0d] got v=%b d=%h occ=%0d want 1/21/1", c, n_out_valid, n_out_data, n_occ); end
    end
    stall = 1'b0;
    #1;
    checks++; if (s_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin failures++; $display("FAIL unstall_ready got s=%b n=%b want 1/1", s_in_ready, n_in_ready); end
    tick();
    checks++; if (s_out_data !== 8'h22 || s_out_ctrl !== 2'b10 || s_occ !== 2'd1) begin failures++; $display("FAIL unstall_s got d=%h c=%b occ=%0d want 22/10/1", s_out_data, s_out_ctrl, s_occ); end
    checks++; if (n_out_data !== 8'h22 || n_occ !== 2'd1) begin failures++; $display("FAIL unstall_n got d=%h occ=%0d want 22/1", n_out_data, n_occ); end
    in_valid = 1'b0;
    tick();
    checks++; if (s_occ !== 2'd0 || n_occ !== 2'd0) begin failures++; $display("FAIL unstall_drain got s=%0d n=%0d want 0/0", s_occ, n_occ); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'h31; in_ctrl = 2'b11;
    tick();
    in_data = 8'h32;
    tick();
    checks++; if (s_occ !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d want=2", s_occ); end
    flush = 1'b1; in_data = 8'h33; out_ready = 1'b1;
    tick();
    checks++; if (s_occ !== 2'd0 || s_out_valid !== 1'b0 || s_out_ctrl !== 2'b00) begin failures++; $display("FAIL flush_s got occ=%0d v=%b c=%b want 0/0/00", s_occ, s_out_valid, s_out_ctrl); end
    checks++; if (n_occ !== 2'd0 || n_out_valid !== 1'b0 || n_out_ctrl !== 2'b00) begin failures++; $display("FAIL flush_n got occ=%0d v=%b c=%b want 0/0/00", n_occ, n_out_valid, n_out_ctrl); end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (s_occ !== 2'd0 || s_out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_capture got occ=%0d v=%b want 0/0", s_occ, s_out_valid); end
  endtask

  task automatic test_noskid();
    out_ready = 1'b1;
    in_valid  = 1'b1; in_data = 8'h50; in_ctrl = 2'b01;
    tick();
    checks++; if (n_occ !== 2'd1 || n_out_data !== 8'h50) begin failures++; $display("FAIL noskid_load got occ=%0d d=%h want 1/50", n_occ, n_out_data); end
    in_data = 8'h55; in_ctrl = 2'b10;
    #1;
    checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL noskid_passthru_ready got=%b want=1", n_in_ready); end
    tick();
    checks++; if (n_out_valid !== 1'b1 || n_out_data !== 8'h55 || n_out_ctrl !== 2'b10 || n_occ !== 2'd1) begin failures++; $display("FAIL noskid_replace got v=%b d=%h c=%b occ=%0d want 1/55/10/1", n_out_valid, n_out_data, n_out_ctrl, n_occ); end
    out_ready = 1'b0; in_data = 8'h66; in_ctrl = 2'b11;
    #1;
    checks++; if (n_in_ready !== 1'b0) begin failures++; $display("FAIL noskid_blocked_ready got=%b want=0", n_in_ready); end
    tick();
    checks++; if (n_out_data !== 8'h55 || n_occ !== 2'd1) begin failures++; $display("FAIL noskid_hold got d=%h occ=%0d want 55/1", n_out_data, n_occ); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    checks++; if (n_occ !== 2'd0 || s_occ !== 2'd0) begin failures++; $display("FAIL noskid_drain got n=%0d s=%0d want 0/0", n_occ, s_occ); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'h41; in_ctrl = 2'b01;
    tick();
    in_data = 8'h42;
    tick();
    checks++; if (s_occ !== 2'd2) begin failures++; $display("FAIL arst_pre_occ got=%0d want=2", s_occ); end
    in_valid = 1'b0;
    #2;
    start = 1'b0;
    #1;
    checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || s_out_data !== 8'h00 || s_out_ctrl !== 2'b00) begin failures++; $display("FAIL arst_s got v=%b occ=%0d d=%h c=%b want 0/0/00/00", s_out_valid, s_occ, s_out_data, s_out_ctrl); end
    checks++; if (n_out_valid !== 1'b0 || n_occ !== 2'd0) begin failures++; $display("FAIL arst_n got v=%b occ=%0d want 0/0", n_out_valid, n_occ); end
    #1;
    start = 1'b1;
    in_valid = 1'b1; in_data = 8'h77; in_ctrl = 2'b11; out_ready = 1'b1;
    #1;
    checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL arst_pre_edge got v=%b want 0", s_out_valid); end
    tick();
    checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h77 || s_out_ctrl !== 2'b11 || s_occ !== 2'd1) begin failures++; $display("FAIL arst_first_push got v=%b d=%h c=%b occ=%0d want 1/77/11/1", s_out_valid, s_out_data, s_out_ctrl, s_occ); end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_fill();
    test_stall();
    test_flush();
    test_noskid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
